uart_mem_loader: RTL and testbench



---
 rtl/uart_loader_pkg.sv | 25 ++
 rtl/uart_mem_loader_if.sv | 30 +++
 rtl/uart_loader_timeout.sv | 41 ++++
 rtl/uart_mem_loader.sv | 147 ++++++++++++++
 tb/tb_uart_mem_loader.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared constants for the UART memory loader.
//   OP_WRITE / OP_READ : frame opcode bytes ('W', 'R')
//   RSP_OK / RSP_BAD   : response bytes ('K', '?')
//   state_e            : command engine state encoding
package uart_loader_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;

    typedef enum logic [3:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StData,
        StMemWr,
        StMemRd,
        StRdWait,
        StSend,
        StTxAck,
        StTxDone
    } state_e;

endpackage

// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: UART byte interface, memory port and status of the loader.
//   master : loader side (drives tx_*, mem_* strobes/addr/data, busy, overrun)
//   slave  : environment side (drives rx_*, tx_busy, mem_rdata)
interface uart_mem_loader_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_err;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              overrun;

    modport master (
        input  rx_valid, rx_data, rx_err, tx_busy, mem_rdata,
        output tx_start, tx_data, mem_addr, mem_wdata, mem_we, mem_re, busy, overrun
    );

    modport slave (
        output rx_valid, rx_data, rx_err, tx_busy, mem_rdata,
        input  tx_start, tx_data, mem_addr, mem_wdata, mem_we, mem_re, busy, overrun
    );
endinterface

// File: rtl/uart_loader_timeout.sv
// uart_loader_timeout: inter-byte timeout counter.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : clear counter (byte accepted or not inside a frame)
//   en_i      : count this cycle
//   expired_o : this counting cycle brings the count to TIMEOUT_CYCLES-1
module uart_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_inc;
        end
    end

    // A clear (accepted byte) in the same cycle always beats expiry.
    assign expired_o = en_i && !clr_i && (cnt_inc == Limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: parses 'W' addr_hi addr_lo data / 'R' addr_hi addr_lo frames from the
// UART and performs one byte access on the memory port, returning one response byte.
//   clk, rst : clock, synchronous active-high reset
//   bus      : master modport carrying rx_*, tx_*, mem_*, busy and overrun
module uart_mem_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    uart_mem_loader_if.master         bus
);
    state_e            state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [15:0]       full_addr;
    logic              in_frame, accept, expired;

    assign in_frame  = state_q inside {StAddrHi, StAddrLo, StData};
    assign accept    = bus.rx_valid && !bus.rx_err;
    assign full_addr = {addr_hi_q, bus.rx_data};

    uart_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!in_frame || accept),
        .en_i     (in_frame),
        .expired_o(expired)
    );

    always_comb begin
        state_d      = state_q;
        is_wr_d      = is_wr_q;
        addr_hi_d    = addr_hi_q;
        tx_data_d    = tx_data_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        bus.mem_we   = 1'b0;
        bus.mem_re   = 1'b0;
        bus.tx_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                        is_wr_d = (bus.rx_data == OP_WRITE);
                        state_d = StAddrHi;
                    end else begin
                        tx_data_d = RSP_BAD;
                        state_d   = StSend;
                    end
                end
            end
            StAddrHi: begin
                if (bus.rx_err) begin
                    state_d = StIdle;
                end else if (bus.rx_valid) begin
                    addr_hi_d = bus.rx_data;
                    state_d   = StAddrLo;
                end else if (expired) begin
                    state_d = StIdle;
                end
            end
            StAddrLo: begin
                if (bus.rx_err) begin
                    state_d = StIdle;
                end else if (bus.rx_valid) begin
                    mem_addr_d = full_addr[ADDR_W-1:0];
                    state_d    = is_wr_q ? StData : StMemRd;
                end else if (expired) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (bus.rx_err) begin
                    state_d = StIdle;
                end else if (bus.rx_valid) begin
                    mem_wdata_d = bus.rx_data;
                    state_d     = StMemWr;
                end else if (expired) begin
                    state_d = StIdle;
                end
            end
            StMemWr: begin
                bus.mem_we = 1'b1;
                tx_data_d  = RSP_OK;
                state_d    = StSend;
            end
            StMemRd: begin
                bus.mem_re = 1'b1;
                state_d    = StRdWait;
            end
            StRdWait: begin
                tx_data_d = bus.mem_rdata;
                state_d   = StSend;
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    bus.tx_start = 1'b1;
                    state_d      = StTxAck;
                end
            end
            StTxAck: begin
                if (bus.tx_busy) begin
                    state_d = StTxDone;
                end
            end
            StTxDone: begin
                if (!bus.tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outside IDLE and the frame-collecting states any received byte is dropped.
    assign bus.overrun   = bus.rx_valid && !(in_frame || state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.tx_data   = tx_data_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            is_wr_q     <= 1'b0;
            addr_hi_q   <= '0;
            tx_data_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            addr_hi_q   <= addr_hi_d;
            tx_data_q   <= tx_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: directed frames against a cycle-schedule model of the loader.
// Each frame task books the strobes/responses the frame must produce at their cycles;
// a negedge process compares every cycle against that schedule.
module tb_uart_mem_loader;
    localparam int unsigned AW    = 16;
    localparam int unsigned TO    = 16;
    localparam int          TXLEN = 4;
    localparam int          MAXC  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_mem_loader_if #(.ADDR_W(AW)) bus_if ();

    uart_mem_loader #(
        .ADDR_W        (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected schedule, indexed by cycle.
    bit         exp_we  [MAXC];
    bit         exp_re  [MAXC];
    bit         exp_tx  [MAXC];
    bit         exp_ov  [MAXC];
    logic [15:0] exp_addr[MAXC];
    logic [7:0]  exp_wd [MAXC];
    logic [7:0]  exp_txd[MAXC];

    logic [7:0] exp_mem[0:65535];
    logic [7:0] env_mem[0:65535];

    // Simple UART transmitter: busy for TXLEN cycles after tx_start, or while held.
    logic tx_hold = 1'b0;
    int   tx_cnt  = 0;
    always @(posedge clk) begin
        if (rst) tx_cnt <= 0;
        else if (bus_if.tx_start) tx_cnt <= TXLEN;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign bus_if.tx_busy = tx_hold || (tx_cnt != 0);

    // Memory: read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (bus_if.mem_we) env_mem[bus_if.mem_addr] <= bus_if.mem_wdata;
        if (bus_if.mem_re) bus_if.mem_rdata <= env_mem[bus_if.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cyc < MAXC) begin
            check("mem_we", bus_if.mem_we, exp_we[cyc]);
            check("mem_re", bus_if.mem_re, exp_re[cyc]);
            check("tx_start", bus_if.tx_start, exp_tx[cyc]);
            check("overrun", bus_if.overrun, exp_ov[cyc]);
            check("we_re_exclusive", bus_if.mem_we & bus_if.mem_re, 0);
            if (exp_we[cyc]) begin
                check("wr_addr", bus_if.mem_addr, exp_addr[cyc]);
                check("wr_data", bus_if.mem_wdata, exp_wd[cyc]);
            end
            if (exp_re[cyc]) check("rd_addr", bus_if.mem_addr, exp_addr[cyc]);
            if (exp_tx[cyc]) check("tx_data", bus_if.tx_data, exp_txd[cyc]);
        end
    end

    function automatic logic [7:0] init_val(input int a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_until(input int c);
        while (cyc < c) tick();
    endtask

    // Drives one byte during the current cycle; n returns that cycle number.
    task automatic send(input logic [7:0] b, output int n);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        n = cyc;
        tick();
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, output int n);
        send(8'h57, n);
        send(a[15:8], n);
        send(a[7:0], n);
        send(d, n);
        exp_we[n+1]   = 1'b1;
        exp_addr[n+1] = a;
        exp_wd[n+1]   = d;
        exp_tx[n+2]   = 1'b1;
        exp_txd[n+2]  = 8'h4B;
        exp_mem[a]    = d;
    endtask

    task automatic do_read(input logic [15:0] a, output int n);
        send(8'h52, n);
        send(a[15:8], n);
        send(a[7:0], n);
        exp_re[n+1]   = 1'b1;
        exp_addr[n+1] = a;
        exp_tx[n+3]   = 1'b1;
        exp_txd[n+3]  = exp_mem[a];
    endtask

    task automatic do_bad(input logic [7:0] b, output int n);
        send(b, n);
        exp_tx[n+1]  = 1'b1;
        exp_txd[n+1] = 8'h3F;
    endtask

    int n;

    initial begin
        for (int a = 0; a < 65536; a++) begin
            exp_mem[a] = init_val(a);
            env_mem[a] = init_val(a);
        end
        exp_mem[16'h0010] = 8'h3C;
        env_mem[16'h0010] = 8'h3C;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_err   = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_busy", bus_if.busy, 0);
        check("rst_tx_start", bus_if.tx_start, 0);
        check("rst_mem_we", bus_if.mem_we, 0);
        check("rst_mem_re", bus_if.mem_re, 0);
        check("rst_overrun", bus_if.overrun, 0);
        check("rst_tx_data", bus_if.tx_data, 0);
        check("rst_mem_addr", bus_if.mem_addr, 0);
        check("rst_mem_wdata", bus_if.mem_wdata, 0);
        rst = 1'b0;
        tick();

        // Write 0x1234 <- 0xA5
        do_write(16'h1234, 8'hA5, n);
        check("w_we_lit", bus_if.mem_we, 1);
        check("w_addr_lit", bus_if.mem_addr, 16'h1234);
        check("w_data_lit", bus_if.mem_wdata, 8'hA5);
        idle_until(n + 2);
        check("w_txs_lit", bus_if.tx_start, 1);
        check("w_txd_lit", bus_if.tx_data, 8'h4B);
        idle_until(n + 7);
        check("w_busy_hold", bus_if.busy, 1);
        idle_until(n + 8);
        check("w_busy_release", bus_if.busy, 0);
        idle_until(n + 12);

        // Read 0x0010 -> 0x3C
        do_read(16'h0010, n);
        check("r_re_lit", bus_if.mem_re, 1);
        idle_until(n + 3);
        check("r_txs_lit", bus_if.tx_start, 1);
        check("r_txd_lit", bus_if.tx_data, 8'h3C);
        idle_until(n + 12);

        // Read back the earlier write
        do_read(16'h1234, n);
        idle_until(n + 3);
        check("rb_txd_lit", bus_if.tx_data, 8'hA5);
        idle_until(n + 12);

        // Unknown opcode
        do_bad(8'h41, n);
        check("bad_txs_lit", bus_if.tx_start, 1);
        check("bad_txd_lit", bus_if.tx_data, 8'h3F);
        idle_until(n + 12);

        // Timeout after 57,12 then a normal read
        send(8'h57, n);
        send(8'h12, n);
        idle_until(n + 15);
        check("to_busy_before", bus_if.busy, 1);
        idle_until(n + 16);
        check("to_busy_after", bus_if.busy, 0);
        tick();
        do_read(16'h0001, n);
        idle_until(n + 3);
        check("to_read_lit", bus_if.tx_data, 8'h5B);
        idle_until(n + 12);

        // rx_err after opcode aborts
        send(8'h57, n);
        bus_if.rx_err = 1'b1;
        tick();
        bus_if.rx_err = 1'b0;
        check("err_abort", bus_if.busy, 0);
        tick();

        // rx_err together with rx_valid aborts too
        send(8'h52, n);
        send(8'h00, n);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h34;
        bus_if.rx_err   = 1'b1;
        tick();
        bus_if.rx_valid = 1'b0;
        bus_if.rx_err   = 1'b0;
        check("err_valid_abort", bus_if.busy, 0);

        // rx_err in IDLE is ignored
        bus_if.rx_err = 1'b1;
        tick();
        bus_if.rx_err = 1'b0;
        check("err_idle", bus_if.busy, 0);
        tick();

        do_write(16'h0042, 8'h99, n);
        idle_until(n + 12);
        do_read(16'h0042, n);
        idle_until(n + 12);

        // Overrun while waiting for the transmitter
        tx_hold = 1'b1;
        send(8'h41, n);
        idle_until(n + 3);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h57;
        exp_ov[n+3]     = 1'b1;
        tick();
        bus_if.rx_valid = 1'b0;
        check("ovr_busy", bus_if.busy, 1);
        idle_until(n + 6);
        tx_hold       = 1'b0;
        exp_tx[n+6]   = 1'b1;
        exp_txd[n+6]  = 8'h3F;
        #1;
        check("ovr_txs_lit", bus_if.tx_start, 1);
        idle_until(n + 18);
        check("ovr_done", bus_if.busy, 0);

        // Reset mid-frame
        send(8'h57, n);
        send(8'h12, n);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", bus_if.busy, 0);
        check("mrst_tx_data", bus_if.tx_data, 0);
        check("mrst_mem_addr", bus_if.mem_addr, 0);
        check("mrst_mem_wdata", bus_if.mem_wdata, 0);
        do_bad(8'h34, n);
        check("mrst_opcode", bus_if.tx_data, 8'h3F);
        idle_until(n + 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
